io_cfg_loader: RTL
==================

Name: io_cfg_loader

Overview:
- Serial configuration controller for a row of io_block instances.
- Receives a parity-protected serial bitstream through a valid/ready handshake and assembles one CFG_W-bit config word per io_block in a shadow register.
- Drives all io_block cfg inputs at once, and only after the whole frame has passed parity checks, so pads never see a partial configuration.
- Sits between the bitstream source and the io_block cfg ports.

Parameters:
- N_BLOCKS, 4, number of io_block instances configured per frame
- CFG_W, 6, width of one io_block cfg word

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new frame; honoured in IDLE and ERROR only
- abort  input  1  cancel the frame in progress; honoured in SHIFT only
- bit_in  input  1  serial config data bit
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  loader accepts a bit this cycle
- busy  output  1  frame in progress (SHIFT or COMMIT)
- done  output  1  one-cycle pulse, new cfg_out applied
- err  output  1  parity failure on last frame; held until next start or rst
- cfg_out  output  N_BLOCKS*CFG_W  word k drives io_block k cfg, at cfg_out[k*CFG_W +: CFG_W]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, cfg_out=0 (all io_blocks undriven), done=0, err=0, busy=0, bit_ready=0, counters=0, shadow=0. Reset mid-frame discards the frame and clears cfg_out.
- Frame format:
  - N_BLOCKS records, block 0 first.
  - Each record is CFG_W data bits, MSB first, then one parity bit.
  - The parity bit is the XOR of the data bits (even parity over CFG_W+1 bits).
  - Frame length is N_BLOCKS*(CFG_W+1) bits (28 at defaults).
- Handshake:
  - A bit transfers on a rising edge where bit_valid & bit_ready.
  - bit_ready = (state==SHIFT) & ~abort. This is the only combinational input-to-output path.
  - bit_valid may drop at any time; the loader simply waits.
- Counters:
  - bit_cnt runs 0..CFG_W; word_cnt runs 0..N_BLOCKS-1. Both advance only on transfers.
  - bit_cnt wraps to 0 after the parity bit; word_cnt increments at that wrap.
  - Parity is accumulated in a running XOR register, cleared at each word start.
- States:
  - IDLE: start -> SHIFT, clear counters, err and parity accumulator. Shadow is not cleared; it is fully overwritten by the frame.
  - SHIFT, data-bit transfer (bit_cnt<CFG_W): shift into shadow word word_cnt and XOR into the accumulator.
  - SHIFT, parity-bit transfer (bit_cnt==CFG_W):
    - Mismatch -> ERROR.
    - Match and word_cnt==N_BLOCKS-1 -> COMMIT.
    - Match otherwise -> next word.
  - SHIFT, abort=1 -> IDLE. Any bit offered that cycle is not accepted. cfg_out and err are unchanged.
  - COMMIT (exactly one cycle): cfg_out <= shadow, done <= 1, -> IDLE. The new cfg_out value and done=1 appear together in the cycle after COMMIT. abort is ignored in COMMIT.
  - ERROR: err=1, bit_ready=0, cfg_out keeps its previous committed value. start -> SHIFT and clears err.
- Latency: done is asserted 2 cycles after the edge that accepts the final parity bit.
- busy=1 in SHIFT and COMMIT.
- start in SHIFT or COMMIT is ignored.
- start and abort together in SHIFT: abort wins.
- cfg_out changes only in the cycle after COMMIT, or on rst.

Test Plan:
- Good frame: rst, start, then 28 bits with bit_valid held high.
  - Words: w0=000001 p=1, w1=000010 p=1, w2=000011 p=0, w3=110000 p=0.
  - Required: done pulses once, 2 cycles after the last bit. cfg_out=24'b110000_000011_000010_000001. err=0. busy falls with done.
- Bad parity on word 2: w2=000011 sent with p=1.
  - Required: ERROR entered, err=1, bit_ready=0 for the remaining 7 bits, cfg_out keeps the previous frame's value, done never asserts.
  - Follow with start: err clears.
- Stalled source: same good frame with bit_valid toggling 1,0,0,1...
  - Required: identical cfg_out to the good-frame case. Counters advance only on handshake cycles.
- Abort mid-frame: abort after 10 accepted bits, with bit_valid=1 in the same cycle.
  - Required: bit_ready=0 that cycle, state IDLE, cfg_out and err unchanged.
  - A following full good frame loads correctly.
- Reset mid-frame: rst at bit 15, after a prior committed frame.
  - Required: cfg_out=0 the next cycle, err=0, bit_ready=0 until the next start.
- Ignored start: start pulsed during SHIFT at bit 5.
  - Required: no counter reset; the frame completes normally with the good-frame values.

Source files
------------

// File: rtl/io_cfg_loader.sv
// Serial configuration loader: assembles parity-checked per-block cfg words in a
// shadow register and applies them to every io_block at once after a clean frame.
module io_cfg_loader #(
  parameter int N_BLOCKS = 4,
  parameter int CFG_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [N_BLOCKS*CFG_W-1:0]    cfg_out,
  output logic [1:0]                   dbg_state
);

  localparam int BIT_CW  = $clog2(CFG_W + 1);
  localparam int WORD_CW = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
  localparam logic [BIT_CW-1:0]  PAR_POS   = BIT_CW'(CFG_W);
  localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(N_BLOCKS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [BIT_CW-1:0]             r_bit_cnt;
  logic [WORD_CW-1:0]            r_word_cnt;
  logic                          r_par;
  logic [N_BLOCKS*CFG_W-1:0]     r_shadow;
  logic [N_BLOCKS*CFG_W-1:0]     r_cfg;
  logic                          r_done;
  logic                          r_err;

  logic                          w_xfer;
  logic                          w_clr;
  logic                          w_commit;
  logic                          w_par_bit;
  logic                          w_par_bad;

  // Handshake: a bit moves on a rising edge where bit_valid & bit_ready. bit_ready
  // depends only on state and abort; bit_valid may drop at any time.
  assign bit_ready = (r_state == S_SHIFT) & ~abort;
  assign w_xfer    = bit_valid & bit_ready;
  assign w_par_bit = (r_bit_cnt == PAR_POS);
  assign w_par_bad = r_par ^ bit_in;

  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_SHIFT;
          w_clr  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_xfer && w_par_bit) begin
          if (w_par_bad)                     w_next = S_ERROR;
          else if (r_word_cnt == LAST_WORD)  w_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_next   = S_IDLE;
        w_commit = 1'b1;
      end
      S_ERROR: begin
        if (start) begin
          w_next = S_SHIFT;
          w_clr  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_par      <= 1'b0;
      r_shadow   <= '0;
      r_cfg      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_commit;
      if (w_commit) r_cfg <= r_shadow;
      if (w_clr) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_par      <= 1'b0;
        r_err      <= 1'b0;
      end else if (w_xfer) begin
        if (w_par_bit) begin
          r_bit_cnt  <= '0;
          r_par      <= 1'b0;
          r_word_cnt <= (r_word_cnt == LAST_WORD) ? '0 : r_word_cnt + WORD_CW'(1);
          if (w_par_bad) r_err <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
          r_par     <= r_par ^ bit_in;
          // Data arrives MSB first, so shifting left lands each word in order.
          for (int k = 0; k < N_BLOCKS; k++) begin
            if (r_word_cnt == WORD_CW'(k))
              r_shadow[k*CFG_W +: CFG_W] <= {r_shadow[k*CFG_W +: CFG_W-1], bit_in};
          end
        end
      end
    end
  end

  assign busy      = (r_state == S_SHIFT) | (r_state == S_COMMIT);
  assign done      = r_done;
  assign err       = r_err;
  assign cfg_out   = r_cfg;
  assign dbg_state = r_state;

endmodule
